// File: rtl/decoder_onehot_pulse.sv
// ---------------------------------------------------------------------------
// decoder_onehot_pulse
//
// Sequential binary-to-one-hot decoder, companion of the 4x2 encoder.
// A binary code is accepted over a valid/ready handshake. The matching
// one-hot line on y is then driven for exactly HOLD cycles. After that, y is
// held at zero for GAP cycles, and the block returns to IDLE with a one-cycle
// done pulse. Typical loads are mux selects and LED/row strobes.
//
// Parameters
//   N     code width; y is 2**N lines wide
//   HOLD  cycles y stays one-hot per accepted code (>= 1)
//   GAP   cycles y is forced to 0 after HOLD (>= 0)
//
// Ports
//   clk       in   1     rising-edge clock
//   rst_n     in   1     synchronous, active-low reset
//   en        in   1     block enable; 0 aborts any pulse and blocks acceptance
//   x         in   N     binary code to decode
//   in_valid  in   1     x is valid this cycle
//   in_ready  out  1     block can accept x (combinational: en && IDLE)
//   y         out  2**N  registered one-hot output, 0 when idle
//   busy      out  1     registered; 1 in ACTIVE or GAP
//   done      out  1     registered one-cycle pulse on normal return to IDLE
// ---------------------------------------------------------------------------
module decoder_onehot_pulse #(
  parameter int unsigned N    = 2,
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N-1:0]      x,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2**N-1:0]   y,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LINES = 2**N;
  localparam int unsigned MAXC  = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CW    = $clog2(MAXC + 1);

  // Counter reload values. GAP may be 0, so its reload is guarded to avoid
  // wrapping -1 into the counter (that branch is unreachable when GAP == 0).
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [N-1:0]      code, code_d;
  logic [LINES-1:0]  y_d;
  logic              busy_d;
  logic              done_d;

  function automatic logic [LINES-1:0] onehot(input logic [N-1:0] c);
    onehot    = '0;
    onehot[c] = 1'b1;
  endfunction

  // Ready only depends on enable and the current state, not on in_valid.
  // This keeps the handshake free of combinational loops through the source.
  assign in_ready = en && (state == S_IDLE);

  // Next-state and next-output logic.
  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    code_d  = code;
    y_d     = y;
    done_d  = 1'b0;

    if (!en) begin
      // An abort is not a completion, so done stays low here.
      state_d = S_IDLE;
      cnt_d   = '0;
      y_d     = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          y_d = '0;
          // en is already known to be 1 on this path, so in_ready is true.
          if (in_valid) begin
            state_d = S_ACTIVE;
            code_d  = x;
            cnt_d   = HOLD_LOAD;
            y_d     = onehot(x);
          end
        end

        S_ACTIVE: begin
          // y is rebuilt from the registered code, so it can only ever hold
          // that one line. x is not looked at again until the next accept.
          y_d = onehot(code);
          if (cnt != '0) begin
            cnt_d = cnt - 1'b1;
          end else if (GAP == 0) begin
            state_d = S_IDLE;
            y_d     = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            y_d     = '0;
            cnt_d   = GAP_LOAD;
          end
        end

        S_GAP: begin
          y_d = '0;
          if (cnt != '0) begin
            cnt_d = cnt - 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          y_d     = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // see the pre-edge values, whatever order the assignments are written in.
  // NOTE: the reset is synchronous. rst_n is sampled only at the rising clock
  // edge, so it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      code  <= '0;
      y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      code  <= code_d;
      y     <= y_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_decoder_onehot_pulse.sv
// ---------------------------------------------------------------------------
// tb_decoder_onehot_pulse
//
// Directed bench for decoder_onehot_pulse. There are two instances:
//   dut0 : defaults (N=2, HOLD=4, GAP=1)
//   dut1 : N=2, HOLD=1, GAP=0
// Each cycle the bench compares a packed status {y, busy, done, in_ready}
// against hand-computed constants.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_decoder_onehot_pulse;

  logic       clk;
  logic       rst_n, en, in_valid, in_ready;
  logic [1:0] x;
  logic [3:0] y;
  logic       busy, done;

  logic       rst_n1, en1, in_valid1, in_ready1;
  logic [1:0] x1;
  logic [3:0] y1;
  logic       busy1, done1;

  logic [6:0] st0, st1;
  logic [6:0] exp_st;

  int vectors;
  int miscompares;

  decoder_onehot_pulse #(.N(2), .HOLD(4), .GAP(1)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .x        (x),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .busy     (busy),
    .done     (done)
  );

  decoder_onehot_pulse #(.N(2), .HOLD(1), .GAP(0)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n1),
    .en       (en1),
    .x        (x1),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .y        (y1),
    .busy     (busy1),
    .done     (done1)
  );

  assign st0 = {y, busy, done, in_ready};
  assign st1 = {y1, busy1, done1, in_ready1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status layout: {y[3:0], busy, done, in_ready}
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; x = 2'd0;
    rst_n1 = 1'b0; en1 = 1'b1; in_valid1 = 1'b0; x1 = 2'd0;
    tick();
    tick();
    vectors++;
    if (st0 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL reset_hold dut0 got=%b exp=%b", st0, 7'b0000_001);
    end
    rst_n = 1'b1; rst_n1 = 1'b1;
    tick();
    vectors++;
    if (st0 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL reset_release dut0 got=%b exp=%b", st0, 7'b0000_001);
    end
    vectors++;
    if (st1 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL reset_release dut1 got=%b exp=%b", st1, 7'b0000_001);
    end
  endtask

  task automatic test_basic();
    x = 2'd2; in_valid = 1'b1;
    tick();                       // accept edge
    in_valid = 1'b0;
    x = 2'd1;                     // must not affect the pulse in flight
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (st0 !== 7'b0100_100) begin
        miscompares++;
        $display("FAIL basic_active[%0d] got=%b exp=%b", i, st0, 7'b0100_100);
      end
      tick();
    end
    vectors++;
    if (st0 !== 7'b0000_100) begin
      miscompares++;
      $display("FAIL basic_gap got=%b exp=%b", st0, 7'b0000_100);
    end
    tick();
    vectors++;
    if (st0 !== 7'b0000_011) begin
      miscompares++;
      $display("FAIL basic_done got=%b exp=%b", st0, 7'b0000_011);
    end
    tick();
    vectors++;
    if (st0 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL basic_idle got=%b exp=%b", st0, 7'b0000_001);
    end
  endtask

  // in_valid stays high across all four codes. A new code is accepted
  // on the edge right after each done cycle, so accepts are 6 cycles apart.
  task automatic test_sweep();
    logic [3:0] line;
    x = 2'd0; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();                     // accept edge for code c
      line = 4'b0001 << c;
      for (int i = 0; i < 4; i++) begin
        exp_st = {line, 3'b100};
        vectors++;
        if (st0 !== exp_st) begin
          miscompares++;
          $display("FAIL sweep_active c=%0d i=%0d got=%b exp=%b", c, i, st0, exp_st);
        end
        tick();
      end
      vectors++;
      if (st0 !== 7'b0000_100) begin
        miscompares++;
        $display("FAIL sweep_gap c=%0d got=%b exp=%b", c, st0, 7'b0000_100);
      end
      tick();
      vectors++;
      if (st0 !== 7'b0000_011) begin
        miscompares++;
        $display("FAIL sweep_done c=%0d got=%b exp=%b", c, st0, 7'b0000_011);
      end
      if (c < 3) x = 2'(c + 1);
      else       in_valid = 1'b0;
    end
    tick();
    vectors++;
    if (st0 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL sweep_idle got=%b exp=%b", st0, 7'b0000_001);
    end
  endtask

  task automatic test_abort();
    x = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (st0 !== 7'b1000_100) begin
      miscompares++;
      $display("FAIL abort_active1 got=%b exp=%b", st0, 7'b1000_100);
    end
    tick();
    vectors++;
    if (st0 !== 7'b1000_100) begin
      miscompares++;
      $display("FAIL abort_active2 got=%b exp=%b", st0, 7'b1000_100);
    end
    en = 1'b0;                    // drop enable on the 2nd ACTIVE cycle
    tick();
    vectors++;
    if (st0 !== 7'b0000_000) begin
      miscompares++;
      $display("FAIL abort_cleared got=%b exp=%b", st0, 7'b0000_000);
    end
    // While disabled, no done pulse appears and a valid code is refused.
    x = 2'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (st0 !== 7'b0000_000) begin
        miscompares++;
        $display("FAIL abort_disabled[%0d] got=%b exp=%b", i, st0, 7'b0000_000);
      end
    end
    in_valid = 1'b0;
    en = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_reenable_ready got=%b exp=%b", in_ready, 1'b1);
    end
    tick();
    vectors++;
    if (st0 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL abort_reenable_idle got=%b exp=%b", st0, 7'b0000_001);
    end
  endtask

  task automatic test_busy_ignore();
    x = 2'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (st0 !== 7'b0001_100) begin
        miscompares++;
        $display("FAIL ignore_active[%0d] got=%b exp=%b", i, st0, 7'b0001_100);
      end
      // Offer a new code during the 2nd ACTIVE cycle. It must be dropped.
      if (i == 1) begin
        x = 2'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    vectors++;
    if (st0 !== 7'b0000_100) begin
      miscompares++;
      $display("FAIL ignore_gap got=%b exp=%b", st0, 7'b0000_100);
    end
    tick();
    vectors++;
    if (st0 !== 7'b0000_011) begin
      miscompares++;
      $display("FAIL ignore_done got=%b exp=%b", st0, 7'b0000_011);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (st0 !== 7'b0000_001) begin
        miscompares++;
        $display("FAIL ignore_no_second[%0d] got=%b exp=%b", i, st0, 7'b0000_001);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    x = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    vectors++;
    if (st0 !== 7'b0010_100) begin
      miscompares++;
      $display("FAIL midrst_active got=%b exp=%b", st0, 7'b0010_100);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (st0 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL midrst_cleared got=%b exp=%b", st0, 7'b0000_001);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (st0 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL midrst_after got=%b exp=%b", st0, 7'b0000_001);
    end
  endtask

  // HOLD=1, GAP=0: one-cycle pulse, done on the following cycle, and an
  // accept-to-accept period of 2 cycles with in_valid held high.
  task automatic test_short();
    x1 = 2'd1; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    vectors++;
    if (st1 !== 7'b0010_100) begin
      miscompares++;
      $display("FAIL short_active got=%b exp=%b", st1, 7'b0010_100);
    end
    tick();
    vectors++;
    if (st1 !== 7'b0000_011) begin
      miscompares++;
      $display("FAIL short_done got=%b exp=%b", st1, 7'b0000_011);
    end
    tick();
    vectors++;
    if (st1 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL short_idle got=%b exp=%b", st1, 7'b0000_001);
    end
    x1 = 2'd2; in_valid1 = 1'b1;
    tick();
    vectors++;
    if (st1 !== 7'b0100_100) begin
      miscompares++;
      $display("FAIL short_b2b_first got=%b exp=%b", st1, 7'b0100_100);
    end
    x1 = 2'd3;
    tick();
    vectors++;
    if (st1 !== 7'b0000_011) begin
      miscompares++;
      $display("FAIL short_b2b_done got=%b exp=%b", st1, 7'b0000_011);
    end
    tick();
    in_valid1 = 1'b0;
    vectors++;
    if (st1 !== 7'b1000_100) begin
      miscompares++;
      $display("FAIL short_b2b_second got=%b exp=%b", st1, 7'b1000_100);
    end
    rst_n1 = 1'b0;                // reset while the pulse is on y
    tick();
    vectors++;
    if (st1 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL short_midrst got=%b exp=%b", st1, 7'b0000_001);
    end
    rst_n1 = 1'b1;
    tick();
    vectors++;
    if (st1 !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL short_midrst_after got=%b exp=%b", st1, 7'b0000_001);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_sweep();
    test_abort();
    test_busy_ignore();
    test_reset_mid_pulse();
    test_short();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
